bram_arb_2p: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one single-port BRAM instance (synchronous read, 1-cycle latency, no byte enables, read data held during writes) between two req/gnt/rvalid memory requesters. It sits between the RT-SS interconnect and the FPGA on-chip RAM. It turns byte-enabled partial writes into read-modify-write sequences, so masters see a byte-addressable memory.

---
 rtl/bram_arb_2p.sv | 166 ++++++++++++++++
 tb/tb_bram_arb_2p.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arb_2p.sv
// Round-robin arbiter sharing one single-port BRAM between two req/gnt/rvalid ports.
// Define BRAM_ARB_RMW_EN to turn partial byte-enable writes into read-modify-write.
module bram_arb_2p #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    bram_en_o,
  output logic                    bram_we_o,
  output logic [ADDR_WIDTH-1:0]   bram_addr_o,
  output logic [DATA_WIDTH-1:0]   bram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   bram_rdata_i
);

  localparam int NUM_BE = DATA_WIDTH / 8;

  // Handshake: a master holds req and payload until gnt is seen high in the same
  // cycle; payload is taken only then. Exactly one rvalid follows per grant, in order.
  logic                  any_req;
  logic                  sel;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [NUM_BE-1:0]     req_be;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic grant;
  logic rsp_set;
  logic rsp_set_port;
  logic rsp_set_read;
  logic prio;
  logic rvalid0;
  logic rvalid1;
  logic rsp_read;

  // With both ports requesting, prio picks the winner; otherwise the lone requester wins.
  assign any_req   = p0_req_i | p1_req_i;
  assign sel       = (p0_req_i & p1_req_i) ? prio : p1_req_i;
  assign req_addr  = sel ? p1_addr_i  : p0_addr_i;
  assign req_we    = sel ? p1_we_i    : p0_we_i;
  assign req_be    = sel ? p1_be_i    : p0_be_i;
  assign req_wdata = sel ? p1_wdata_i : p0_wdata_i;

`ifdef BRAM_ARB_RMW_EN
  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  partial;
  logic                  lat_port;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [NUM_BE-1:0]     lat_be;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] merged;

  assign partial = req_we & (|req_be) & ~(&req_be);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (grant && partial) begin
      lat_port  <= sel;
      lat_addr  <= req_addr;
      lat_be    <= req_be;
      lat_wdata <= req_wdata;
    end
  end

  always_comb begin
    merged = bram_rdata_i;
    for (int b = 0; b < NUM_BE; b++) begin
      if (lat_be[b]) merged[8*b +: 8] = lat_wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_nxt    = state;
    grant        = 1'b0;
    rsp_set      = 1'b0;
    rsp_set_port = sel;
    rsp_set_read = ~req_we;
    bram_en_o    = 1'b0;
    bram_we_o    = 1'b0;
    bram_addr_o  = req_addr;
    bram_wdata_o = req_wdata;
    case (state)
      IDLE: begin
        if (any_req && !rst_i) begin
          grant     = 1'b1;
          rsp_set   = ~partial;
          bram_en_o = ~req_we | (|req_be);
          bram_we_o = req_we & (&req_be);
          if (partial) state_nxt = RMW_WR;
        end
      end
      RMW_WR: begin
        // Old word from the read issued at grant time is on bram_rdata_i now.
        bram_en_o    = ~rst_i;
        bram_we_o    = ~rst_i;
        bram_addr_o  = lat_addr;
        bram_wdata_o = merged;
        rsp_set      = 1'b1;
        rsp_set_port = lat_port;
        rsp_set_read = 1'b0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  logic unused_be;
  assign unused_be = ^{p0_be_i, p1_be_i};

  always_comb begin
    grant        = any_req & ~rst_i;
    rsp_set      = grant;
    rsp_set_port = sel;
    rsp_set_read = ~req_we;
    bram_en_o    = grant;
    bram_we_o    = grant & req_we;
    bram_addr_o  = req_addr;
    bram_wdata_o = req_wdata;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rsp_read <= 1'b0;
    end else begin
      if (grant) prio <= ~sel;
      rvalid0  <= rsp_set & ~rsp_set_port;
      rvalid1  <= rsp_set & rsp_set_port;
      rsp_read <= rsp_set & rsp_set_read;
    end
  end

  assign p0_gnt_o    = grant & ~sel;
  assign p1_gnt_o    = grant & sel;
  assign p0_rvalid_o = rvalid0;
  assign p1_rvalid_o = rvalid1;
  assign p0_rdata_o  = (rvalid0 && rsp_read) ? bram_rdata_i : '0;
  assign p1_rdata_o  = (rvalid1 && rsp_read) ? bram_rdata_i : '0;

endmodule

// File: tb/tb_bram_arb_2p.sv
// Bench for bram_arb_2p: directed reset/contention/RMW cases, then random traffic
// scored against a transaction-level memory and round-robin model.
module tb_bram_arb_2p;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req, p0_gnt, p0_we, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [3:0]    p0_be;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_gnt, p1_we, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [3:0]    p1_be;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata, bram_rdata;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] ref_mem [0:15];
  logic [DW-1:0] exp_q [2][$];
  int            exp_cyc [2][$];
  logic          last_gnt;
  logic          rmw_block;
  logic          g_seen [2];

  bram_arb_2p dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
    .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
    .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
    .bram_wdata_o(bram_wdata), .bram_rdata_i(bram_rdata)
  );

  // clock / BRAM model with a backdoor preload path
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata <= mem[bram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [DW-1:0] wd);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = a; p0_be = be; p0_wdata = wd;
    end else begin
      p1_req = req; p1_we = we; p1_addr = a; p1_be = be; p1_wdata = wd;
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic drive_random();
    logic [3:0] be;
    for (int p = 0; p < 2; p++) begin
      if (!(p == 0 ? p0_req : p1_req) || g_seen[p]) begin
        case ($urandom_range(0, 3))
          0: be = 4'h0;
          1: be = 4'hF;
          default: be = 4'($urandom_range(0, 15));
        endcase
        drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)), be, $urandom);
      end
    end
  endtask

  // Scoreboard step: responses against queues, grants against round-robin rules,
  // then apply the granted transaction to the reference memory.
  task automatic monitor(input int c);
    logic          rv, eg0, eg1, we, partial;
    logic [DW-1:0] rd, wd;
    logic [3:0]    a, be;
    int            p, lat;
    for (int q = 0; q < 2; q++) begin
      rv = (q == 0) ? p0_rvalid : p1_rvalid;
      rd = (q == 0) ? p0_rdata : p1_rdata;
      if (rv) begin
        if (exp_q[q].size() == 0) check($sformatf("p%0d_rvalid_extra", q), 1, 0);
        else begin
          check($sformatf("p%0d_rsp_cycle", q), c, exp_cyc[q].pop_front());
          check($sformatf("p%0d_rdata", q), rd, exp_q[q].pop_front());
        end
      end else begin
        check($sformatf("p%0d_rdata_idle", q), rd, 0);
        if (exp_cyc[q].size() > 0 && exp_cyc[q][0] <= c) begin
          check($sformatf("p%0d_rvalid_missing", q), 0, 1);
          void'(exp_cyc[q].pop_front());
          void'(exp_q[q].pop_front());
        end
      end
    end
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rmw_block) begin
      if (p0_req && p1_req) begin
        if (last_gnt) eg0 = 1'b1; else eg1 = 1'b1;
      end else if (p0_req) eg0 = 1'b1;
      else if (p1_req) eg1 = 1'b1;
    end
    check("gnt0", p0_gnt, eg0);
    check("gnt1", p1_gnt, eg1);
    g_seen[0] = p0_gnt;
    g_seen[1] = p1_gnt;
    partial = 1'b0;
    if (eg0 || eg1) begin
      p  = eg1 ? 1 : 0;
      a  = eg1 ? p1_addr[3:0] : p0_addr[3:0];
      we = eg1 ? p1_we : p0_we;
      be = eg1 ? p1_be : p0_be;
      wd = eg1 ? p1_wdata : p0_wdata;
      last_gnt = eg1;
      lat = 1;
      if (!we) exp_q[p].push_back(ref_mem[a]);
      else begin
        exp_q[p].push_back('0);
`ifdef BRAM_ARB_RMW_EN
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        partial = (be != 4'h0) && (be != 4'hF);
        if (partial) lat = 2;
`else
        ref_mem[a] = wd;
`endif
      end
      exp_cyc[p].push_back(c + lat);
    end
    rmw_block = partial;
  endtask

  initial begin
    int cyc;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    preload(14'h10, 32'hA5A50010);
    preload(14'h20, 32'h5A5A0020);

    // reset values with both ports requesting
    drive(0, 1'b1, 1'b0, 14'h10, 4'h0, '0);
    drive(1, 1'b1, 1'b0, 14'h20, 4'h0, '0);
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt0", p0_gnt, 0);
      check("rst_gnt1", p1_gnt, 0);
      check("rst_rvalid0", p0_rvalid, 0);
      check("rst_rvalid1", p1_rvalid, 0);
      check("rst_bram_en", bram_en, 0);
      tick();
    end
    rst = 1'b0;

    // contention: alternating grants, each read answered one cycle later
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("cont_gnt0", p0_gnt, (k % 2) == 0);
      check("cont_gnt1", p1_gnt, (k % 2) == 1);
      if (k > 0) begin
        check("cont_rvalid0", p0_rvalid, (k % 2) == 1);
        check("cont_rvalid1", p1_rvalid, (k % 2) == 0);
        check("cont_rdata", (k % 2) ? p0_rdata : p1_rdata, (k % 2) ? 32'hA5A50010 : 32'h5A5A0020);
      end
      tick();
    end
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("cont_last_rvalid1", p1_rvalid, 1);
    check("cont_last_rdata1", p1_rdata, 32'h5A5A0020);
    tick();

`ifdef BRAM_ARB_RMW_EN
    // partial write with grant blocking during the merge cycle
    preload(14'd5, 32'hAABBCCDD);
    drive(0, 1'b1, 1'b1, 14'd5, 4'b0101, 32'h11223344);
    @(negedge clk);
    check("rmw_t_gnt0", p0_gnt, 1);
    check("rmw_t_en", bram_en, 1);
    check("rmw_t_we", bram_we, 0);
    check("rmw_t_addr", bram_addr, 5);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, 14'd5, 4'h0, '0);
    @(negedge clk);
    check("rmw_t1_gnt0", p0_gnt, 0);
    check("rmw_t1_gnt1", p1_gnt, 0);
    check("rmw_t1_en", bram_en, 1);
    check("rmw_t1_we", bram_we, 1);
    check("rmw_t1_addr", bram_addr, 5);
    check("rmw_t1_wdata", bram_wdata, 32'hAA22CC44);
    check("rmw_t1_rvalid0", p0_rvalid, 0);
    tick();
    @(negedge clk);
    check("rmw_t2_gnt1", p1_gnt, 1);
    check("rmw_t2_rvalid0", p0_rvalid, 1);
    check("rmw_t2_rdata0", p0_rdata, 0);
    tick();
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("rmw_t3_rvalid1", p1_rvalid, 1);
    check("rmw_t3_rdata1", p1_rdata, 32'hAA22CC44);
    tick();

    // reset arriving in the merge cycle abandons the write and its response
    preload(14'd7, 32'h55667788);
    drive(0, 1'b1, 1'b1, 14'd7, 4'b0011, 32'hDEADBEEF);
    @(negedge clk);
    check("rrst_gnt0", p0_gnt, 1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    check("rrst_bram_en", bram_en, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rrst_rvalid0", p0_rvalid, 0);
    check("rrst_rvalid1", p1_rvalid, 0);
    tick();
    drive(1, 1'b1, 1'b0, 14'd7, 4'h0, '0);
    @(negedge clk);
    check("rrst_rd_gnt1", p1_gnt, 1);
    tick();
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("rrst_rd_rvalid1", p1_rvalid, 1);
    check("rrst_rd_rdata1", p1_rdata, 32'h55667788);
    tick();
`else
    // byte enables ignored: every write is a single-cycle full-word write
    preload(14'd5, 32'hAABBCCDD);
    drive(0, 1'b1, 1'b1, 14'd5, 4'b0101, 32'h11223344);
    @(negedge clk);
    check("fw_gnt0", p0_gnt, 1);
    check("fw_en", bram_en, 1);
    check("fw_we", bram_we, 1);
    check("fw_wdata", bram_wdata, 32'h11223344);
    tick();
    drive(0, 1'b1, 1'b0, 14'd5, 4'h0, '0);
    @(negedge clk);
    check("fw_rvalid0", p0_rvalid, 1);
    check("fw_rdata0", p0_rdata, 0);
    check("fw_rd_gnt0", p0_gnt, 1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("fw_rd_rvalid0", p0_rvalid, 1);
    check("fw_rd_rdata0", p0_rdata, 32'h11223344);
    tick();
`endif

    // random traffic against the reference model
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      preload(AW'(a), ref_mem[a]);
    end
    rst = 1'b0;
    last_gnt = 1'b1;
    rmw_block = 1'b0;
    g_seen[0] = 1'b0;
    g_seen[1] = 1'b0;
    cyc = 0;
    repeat (400) begin
      @(negedge clk);
      monitor(cyc);
      cyc++;
      tick();
      drive_random();
    end
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (6) begin
      @(negedge clk);
      monitor(cyc);
      cyc++;
      tick();
    end
    check("drain_q0", exp_q[0].size(), 0);
    check("drain_q1", exp_q[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
